// File: rtl/rv32i_pkg.sv
// Shared load/store encodings and FSM state type for the load_store_unit slice.
// Misalignment trapping is selected elsewhere with the MISALIGN_TRAP_EN macro.
package rv32i_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } lsu_state_t;

    function automatic logic fun3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == SB) || (f3 == SH) || (f3 == SW);
        return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    endfunction

    // fun3[1:0] encodes access width for loads and stores alike
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] align_low(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return {lo[1], 1'b0};
            2'b10:   return 2'b00;
            default: return lo;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data lane select with sign/zero extension.
module load_extend
    import rv32i_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  fun3,
    output logic [31:0] result
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        shifted  = mem_rdata >> {addr, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (fun3)
            LB:      result = {{24{byte_sel[7]}}, byte_sel};
            LH:      result = {{16{half_sel[15]}}, half_sel};
            LW:      result = mem_rdata;
            LBU:     result = {24'h0, byte_sel};
            LHU:     result = {16'h0, half_sel};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store bus master with bus timeout.
// Define MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them down.
module load_store_unit
    import rv32i_pkg::*;
#(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        store,
    input  logic [2:0]  fun3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(BUS_TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(BUS_TIMEOUT - 1);

    lsu_state_t    state, state_nxt;
    logic [2:0]    fun3_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          store_q;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic          req_legal;
    logic          req_bad;
    logic          timeout;
    logic [31:0]   addr_eff;
    logic [31:0]   ext_data;

    always_comb begin
        req_legal = 1'b0;
        req_bad   = 1'b0;
        if (load && store) begin
            req_bad = 1'b1;
        end else if (load || store) begin
            if (!fun3_legal(store, fun3))
                req_bad = 1'b1;
`ifdef MISALIGN_TRAP_EN
            else if (misaligned(fun3, addr[1:0]))
                req_bad = 1'b1;
`endif
            else
                req_legal = 1'b1;
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign addr_eff = addr;
`else
    assign addr_eff = {addr[31:2], align_low(fun3, addr[1:0])};
`endif

    assign timeout = (state == REQ) && !mem_ack && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_legal) state_nxt = REQ;
            REQ: begin
                if (mem_ack)
                    state_nxt = RESP;
                else if (timeout)
                    state_nxt = IDLE;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    load_extend u_load_extend (
        .mem_rdata (mem_rdata),
        .addr      (addr_q[1:0]),
        .fun3      (fun3_q),
        .result    (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fun3_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            store_q  <= 1'b0;
            wait_cnt <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= ((state == IDLE) && req_bad) || timeout;
            if (state == IDLE && req_legal) begin
                fun3_q   <= fun3;
                addr_q   <= addr_eff;
                wdata_q  <= wdata;
                store_q  <= store;
                wait_cnt <= '0;
            end else if (state == REQ) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == REQ && mem_ack)
                rdata_q <= store_q ? '0 : ext_data;
        end
    end

    // Bus outputs derive only from captured request state, so they hold until ack
    always_comb begin
        mem_req   = (state == REQ);
        mem_we    = mem_req && store_q;
        mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : '0;
        mem_wstrb = '0;
        mem_wdata = '0;
        if (mem_req && store_q) begin
            case (fun3_q[1:0])
                2'b00: begin
                    mem_wstrb = 4'b0001 << addr_q[1:0];
                    mem_wdata = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    mem_wstrb = 4'b0011 << addr_q[1:0];
                    mem_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    mem_wstrb = 4'b1111;
                    mem_wdata = wdata_q;
                end
            endcase
        end
    end

    assign done  = (state == RESP);
    assign err   = err_q;
    assign rdata = rdata_q;
    assign stall = ((state == IDLE) && req_legal) || (state == REQ);

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected bus/response items, a monitor checks them.
module tb_load_store_unit;
    import rv32i_pkg::*;

    localparam int BUS_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        load, store;
    logic [2:0]  fun3;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        done, err, stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    load_store_unit #(.BUS_TIMEOUT(BUS_TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .store     (store),
        .fun3      (fun3),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .done      (done),
        .err       (err),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;

    always @(posedge clk) cycle++;

    typedef struct {
        bit          is_err;
        logic [31:0] rdata;
        int          lat;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_evt(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event occurred with nothing expected (t=%0t)", name, $time);
    endtask

    task automatic push_bus(input logic [31:0] a, input logic we, input logic [3:0] s,
                            input logic [31:0] d);
        bus_t b;
        b.addr = a; b.we = we; b.wstrb = s; b.wdata = d;
        bus_q.push_back(b);
    endtask

    task automatic push_resp(input bit is_err, input logic [31:0] d, input int lat);
        resp_t r;
        r.is_err = is_err; r.rdata = d; r.lat = lat;
        resp_q.push_back(r);
    endtask

    // Monitor: samples on the falling edge, pops expectations on bus start and completion
    initial begin : monitor
        bit    prev_req;
        int    req_cycle;
        bus_t  b;
        resp_t e;
        prev_req  = 1'b0;
        req_cycle = 0;
        forever begin
            @(negedge clk);
            if (mem_req && !prev_req) begin
                req_cycle = cycle;
                if (bus_q.size() == 0) begin
                    fail_evt("unexpected_mem_req");
                end else begin
                    b = bus_q.pop_front();
                    chk("mem_addr",  mem_addr,  b.addr);
                    chk("mem_we",    32'(mem_we), 32'(b.we));
                    chk("mem_wstrb", 32'(mem_wstrb), 32'(b.wstrb));
                    chk("mem_wdata", mem_wdata, b.wdata);
                end
            end
            prev_req = mem_req;
            if (done || err) begin
                if (resp_q.size() == 0) begin
                    fail_evt(done ? "unexpected_done" : "unexpected_err");
                end else begin
                    e = resp_q.pop_front();
                    chk("err_flag",  32'(err),  32'(e.is_err));
                    chk("done_flag", 32'(done), 32'(!e.is_err));
                    if (!e.is_err) chk("rdata", rdata, e.rdata);
                    else           chk("mem_req_at_err", 32'(mem_req), 32'd0);
                    if (e.lat >= 0) chk("latency", 32'(cycle - req_cycle), 32'(e.lat));
                end
            end
        end
    end

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic exp_stall);
        @(posedge clk); #1;
        load = ld; store = st; fun3 = f3; addr = a; wdata = wd;
        #1 chk("stall_on_request", 32'(stall), 32'(exp_stall));
        @(posedge clk); #1;
        load = 1'b0; store = 1'b0;
    endtask

    task automatic respond(input int d, input logic [31:0] rd);
        int waited = 0;
        while (!mem_req && waited < 8) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!mem_req) fail_evt("mem_req_never_rose");
        chk("stall_in_req", 32'(stall), 32'd1);
        repeat (d) begin @(posedge clk); #1; end
        mem_ack = 1'b1; mem_rdata = rd;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = '0;
        chk("stall_in_resp", 32'(stall), 32'd0);
        repeat (2) @(posedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_req"},   32'(mem_req),   32'd0);
        chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
        chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
        chk({tag, "_mem_addr"},  mem_addr,       32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
        chk({tag, "_rdata"},     rdata,          32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
        chk({tag, "_err"},       32'(err),       32'd0);
        chk({tag, "_stall"},     32'(stall),     32'd0);
    endtask

    initial begin : watchdog
        #200000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : stimulus
        rst = 1'b0; load = 1'b0; store = 1'b0; fun3 = '0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        #1 rst = 1'b1;
        #2 check_all_zero("reset");
        #9 rst = 1'b0;

        // lb 0x103, ack two cycles after mem_req
        push_bus(32'h100, 1'b0, 4'b0000, 32'h0);
        push_resp(1'b0, 32'hFFFF_FF80, 3);
        issue(1'b1, 1'b0, LB, 32'h103, 32'h0, 1'b1);
        respond(2, 32'h80FF_0000);

        // sh 0x202
        push_bus(32'h200, 1'b1, 4'b1100, 32'hABCD_ABCD);
        push_resp(1'b0, 32'h0, 1);
        issue(1'b0, 1'b1, SH, 32'h202, 32'h0000_ABCD, 1'b1);
        respond(0, 32'hFFFF_FFFF);

        // sb 0x101
        push_bus(32'h100, 1'b1, 4'b0010, 32'h7878_7878);
        push_resp(1'b0, 32'h0, 2);
        issue(1'b0, 1'b1, SB, 32'h101, 32'h1234_5678, 1'b1);
        respond(1, 32'h0);

        // lhu 0x102
        push_bus(32'h100, 1'b0, 4'b0000, 32'h0);
        push_resp(1'b0, 32'h0000_BEEF, 1);
        issue(1'b1, 1'b0, LHU, 32'h102, 32'h0, 1'b1);
        respond(0, 32'hBEEF_1234);

        // lh 0x100
        push_bus(32'h100, 1'b0, 4'b0000, 32'h0);
        push_resp(1'b0, 32'hFFFF_8001, 1);
        issue(1'b1, 1'b0, LH, 32'h100, 32'h0, 1'b1);
        respond(0, 32'h0000_8001);

        // lbu 0x102
        push_bus(32'h100, 1'b0, 4'b0000, 32'h0);
        push_resp(1'b0, 32'h0000_00AB, 1);
        issue(1'b1, 1'b0, LBU, 32'h102, 32'h0, 1'b1);
        respond(0, 32'h00AB_0000);

        // sw 0x300
        push_bus(32'h300, 1'b1, 4'b1111, 32'hDEAD_BEEF);
        push_resp(1'b0, 32'h0, 1);
        issue(1'b0, 1'b1, SW, 32'h300, 32'hDEAD_BEEF, 1'b1);
        respond(0, 32'h0);

        // lw 0x40
        push_bus(32'h40, 1'b0, 4'b0000, 32'h0);
        push_resp(1'b0, 32'h1234_5678, 1);
        issue(1'b1, 1'b0, LW, 32'h40, 32'h0, 1'b1);
        respond(0, 32'h1234_5678);

        // Illegal requests: both kinds, bad load fun3, bad store fun3
        push_resp(1'b1, 32'h0, -1);
        issue(1'b1, 1'b1, LW, 32'h40, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        push_resp(1'b1, 32'h0, -1);
        issue(1'b1, 1'b0, 3'b011, 32'h40, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        push_resp(1'b1, 32'h0, -1);
        issue(1'b0, 1'b1, 3'b100, 32'h40, 32'h0, 1'b0);
        repeat (3) @(posedge clk);

        // Misaligned lw 0x006
`ifdef MISALIGN_TRAP_EN
        push_resp(1'b1, 32'h0, -1);
        issue(1'b1, 1'b0, LW, 32'h006, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
`else
        push_bus(32'h004, 1'b0, 4'b0000, 32'h0);
        push_resp(1'b0, 32'hCAFE_F00D, 1);
        issue(1'b1, 1'b0, LW, 32'h006, 32'h0, 1'b1);
        respond(0, 32'hCAFE_F00D);
`endif

        // Bus timeout: ack never arrives
        push_bus(32'h80, 1'b0, 4'b0000, 32'h0);
        push_resp(1'b1, 32'h0, BUS_TIMEOUT);
        issue(1'b1, 1'b0, LW, 32'h80, 32'h0, 1'b1);
        repeat (BUS_TIMEOUT + 4) @(posedge clk);
        #1;
        chk("timeout_mem_req", 32'(mem_req), 32'd0);
        chk("timeout_stall",   32'(stall),   32'd0);

        // Reset in REQ, then a late ack that must be ignored
        push_bus(32'h90, 1'b0, 4'b0000, 32'h0);
        issue(1'b1, 1'b0, LW, 32'h90, 32'h0, 1'b1);
        chk("pre_reset_mem_req", 32'(mem_req), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1 check_all_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("post_reset_mem_req", 32'(mem_req), 32'd0);
        chk("post_reset_rdata",   rdata,         32'd0);

        chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
        chk("bus_q_drained",  32'(bus_q.size()),  32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter BUS_TIMEOUT, default 16, giving the cycles mem_req may wait for mem_ack before an error is declared.
REQ-002 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have ports load and store, inputs, 1 bit each: access request from control_decoder.
REQ-005 SHALL have port fun3, input, 3 bits: access width and signedness.
REQ-006 SHALL have ports addr and wdata, inputs, 32 bits each: byte address from the ALU result, and rs2 store data.
REQ-007 SHALL have ports rdata, output, 32 bits (extended load result), done, output, 1 bit (completion pulse), err, output, 1 bit (error pulse) and stall, output, 1 bit (pipeline hold).
REQ-008 SHALL have ports mem_req, mem_we, outputs, 1 bit each; mem_addr, output, 32 bits; mem_wstrb, output, 4 bits; mem_wdata, output, 32 bits.
REQ-009 SHALL have ports mem_ack, input, 1 bit, and mem_rdata, input, 32 bits.

Function
REQ-010 SHALL implement the FSM states IDLE, REQ and RESP.
REQ-011 IDLE SHALL capture fun3, addr and wdata, with the load-or-store kind, when exactly one of load or store is high and fun3 is legal, then enter REQ.
REQ-012 Legal fun3 SHALL be: load 000, 001, 010, 100, 101; store 000, 001, 010; any other value SHALL pulse err for one cycle, issue no bus transaction and stay in IDLE.
REQ-013 load and store high together SHALL pulse err with no transaction.
REQ-014 In REQ, mem_req SHALL be 1; mem_addr SHALL be {addr[31:2],2'b00}; mem_we SHALL equal the store kind.
REQ-015 In REQ, all mem_* outputs SHALL stay stable until mem_ack is sampled high.
REQ-016 Store lanes SHALL be: sb mem_wstrb=0001<<addr[1:0] with the byte replicated ×4; sh mem_wstrb=0011<<addr[1:0] with the halfword replicated ×2; sw mem_wstrb=1111.
REQ-017 Loads SHALL drive mem_wstrb=0000.
REQ-018 On mem_ack in REQ, the FSM SHALL register mem_rdata and go to RESP.
REQ-019 RESP SHALL last one cycle: done=1, rdata valid, then return to IDLE.
REQ-020 rdata SHALL be: lb/lh sign-extended byte/half selected by addr[1:0]; lbu/lhu zero-extended; lw the whole word; stores give rdata=0.
REQ-021 stall SHALL be combinationally 1 in IDLE while a legal request is present, 1 throughout REQ, and 0 in RESP.
REQ-022 End-to-end latency SHALL be request cycle N, earliest mem_req at N+1, done at ack+1.
REQ-023 A wait counter SHALL count REQ cycles; on reaching BUS_TIMEOUT without ack, the unit SHALL drop mem_req, pulse err and return to IDLE; the counter SHALL clear on entering REQ.
REQ-024 mem_ack outside REQ SHALL be ignored.

Reset
REQ-025 rst SHALL force IDLE immediately, including mid-transaction, with mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, rdata=0, done=0, err=0, stall=0 and counter=0.
REQ-026 Normal operation SHALL begin at the first clk edge after rst falls.

Configuration
REQ-027 The macro MISALIGN_TRAP_EN SHALL control misalignment handling.
REQ-028 With MISALIGN_TRAP_EN defined, lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=00, SHALL pulse err in IDLE with no bus transaction.
REQ-029 Without MISALIGN_TRAP_EN, the offending low address bits SHALL be forced to 0 (access aligned down) and no error SHALL be raised.

Structure
REQ-030 Package rv32i_pkg SHALL hold the fun3 width constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the FSM state typedef.
REQ-031 Sub-module load_extend SHALL be combinational: inputs mem_rdata, addr[1:0] and fun3; output the 32-bit extended result.

Verification
REQ-032 lb at addr 0x103 with mem_rdata 0x80FF_0000 and ack after 2 cycles -> mem_addr 0x100, done 3 cycles after mem_req rises, rdata 0xFFFF_FF80.
REQ-033 sh at addr 0x202 with wdata 0x0000_ABCD -> mem_wstrb 1100, mem_wdata 0xABCD_ABCD, mem_we 1, done then rdata 0.
REQ-034 lw with mem_ack held low and BUS_TIMEOUT=16 -> err pulse after 16 REQ cycles, mem_req 0, state IDLE.
REQ-035 lw at addr 0x006: with MISALIGN_TRAP_EN, err=1 and mem_req stays 0; without it, mem_addr 0x004 and normal completion.
REQ-036 load=store=1, and separately load with fun3=011 -> err pulse and no mem_req in either case.
REQ-037 rst asserted in REQ before ack -> all outputs 0 at once; a later ack is ignored and no done occurs.
